eth_tx_arb: RTL and testbench

ETH_TX_ARB -- requirements
Module: eth_tx_arb

---
 rtl/eth_tx_arb.sv | 192 +++++++++++++++++++
 tb/tb_eth_tx_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb.sv
// Round-robin arbiter that lets REQ_N application requesters share one eth_tx pipe.
// Optional stall watchdog: define ETH_TX_ARB_WATCHDOG_EN.
module eth_tx_arb #(
  parameter int REQ_N      = 2,
  parameter int DATA_W     = 16,
  parameter int PKT_LEN_W  = 16,
  parameter int LAST_LEN_W = 4,
  parameter int IFG_CYC    = 3,
  parameter int WDOG_CYC   = 1024,
  localparam int KEEP_W    = DATA_W / 8,
  localparam int LEN_W     = $clog2(KEEP_W + 1)
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic [REQ_N-1:0]            req_v_i,
  input  logic [REQ_N*PKT_LEN_W-1:0]  req_pkt_len_i,
  input  logic [REQ_N-1:0]            req_cancel_i,
  input  logic [REQ_N*DATA_W-1:0]     req_data_i,
  input  logic [REQ_N*LEN_W-1:0]      req_len_i,
  input  logic [REQ_N-1:0]            req_last_i,
  input  logic [REQ_N-1:0]            req_last_block_next_i,
  input  logic [REQ_N*LAST_LEN_W-1:0] req_last_block_next_len_i,
  output logic [REQ_N-1:0]            grant_o,
  output logic [REQ_N-1:0]            req_ready_o,
  output logic                        tx_early_v_o,
  output logic [PKT_LEN_W-1:0]        tx_pkt_len_o,
  output logic                        tx_cancel_o,
  output logic [DATA_W-1:0]           tx_data_o,
  output logic [LEN_W-1:0]            tx_len_o,
  output logic                        tx_last_o,
  output logic                        tx_last_block_next_o,
  output logic [LAST_LEN_W-1:0]       tx_last_block_next_len_o,
  input  logic                        tx_ready_i,
  input  logic                        tx_phy_idle_i
);

  localparam int IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int IFG_W = (IFG_CYC > 0) ? $clog2(IFG_CYC + 1) : 1;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LAUNCH = 5'b00010,
    S_STREAM = 5'b00100,
    S_DRAIN  = 5'b01000,
    S_GAP    = 5'b10000
  } state_t;

  state_t                 r_state;
  logic [REQ_N-1:0]       r_grant;
  logic [IDX_W-1:0]       r_gidx;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IFG_W-1:0]       r_ifg;
  logic [PKT_LEN_W-1:0]   r_pkt_len;
  logic                   r_early_v;
  logic                   r_cancel;

  logic                   w_stream;
  logic                   w_any;
  logic [IDX_W-1:0]       w_win;
  logic [REQ_N-1:0]       w_win_oh;
  logic [IDX_W-1:0]       w_rr_next;
  logic                   w_owned;
  logic                   w_wdog_hit;
  logic                   w_cancel;

  assign w_stream = (r_state == S_STREAM);
  assign w_owned  = (r_state == S_LAUNCH) || w_stream || (r_state == S_DRAIN);

  // Round-robin search: first requester at or after r_rr_ptr
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    for (int k = 0; k < REQ_N; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % REQ_N;
      if (!w_any && req_v_i[idx]) begin
        w_any = 1'b1;
        w_win = IDX_W'(idx);
      end
    end
    w_win_oh[w_win] = 1'b1;
  end

  assign w_rr_next = (r_gidx == IDX_W'(REQ_N - 1)) ? '0 : r_gidx + IDX_W'(1);

`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              w_busy;

  assign w_busy     = (r_state == S_LAUNCH) || w_stream;
  // Fires on the WDOG_CYC-th consecutive busy cycle without an accepted beat
  assign w_wdog_hit = w_busy && !(|req_ready_o) && (r_wdog == WDOG_W'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_wdog <= '0;
    end else if (!w_busy || (|req_ready_o)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end
  end
`else
  assign w_wdog_hit = (WDOG_CYC < 0);
`endif

  assign w_cancel = w_owned && (req_cancel_i[r_gidx] || w_wdog_hit);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_gidx    <= '0;
      r_rr_ptr  <= '0;
      r_ifg     <= '0;
      r_early_v <= 1'b0;
      r_cancel  <= 1'b0;
    end else begin
      r_early_v <= 1'b0;
      r_cancel  <= 1'b0;
      if (w_cancel) begin
        r_cancel <= 1'b1;
        r_grant  <= '0;
        r_rr_ptr <= w_rr_next;
        if (IFG_CYC == 0) begin
          r_state <= S_IDLE;
        end else begin
          r_state <= S_GAP;
          r_ifg   <= IFG_W'(IFG_CYC);
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_any && tx_phy_idle_i) begin
              r_grant   <= w_win_oh;
              r_gidx    <= w_win;
              r_early_v <= 1'b1;
              r_state   <= S_LAUNCH;
            end
          end
          S_LAUNCH: r_state <= S_STREAM;
          S_STREAM: begin
            if (tx_ready_i && tx_last_o) r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (tx_phy_idle_i) begin
              r_grant  <= '0;
              r_rr_ptr <= w_rr_next;
              if (IFG_CYC == 0) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_GAP;
                r_ifg   <= IFG_W'(IFG_CYC);
              end
            end
          end
          S_GAP: begin
            if (r_ifg <= IFG_W'(1)) begin
              r_ifg   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_ifg <= r_ifg - IFG_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        endcase
      end
    end
  end

  // Length tracks the current winner while idle, so it holds the granted value in LAUNCH
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) r_pkt_len <= req_pkt_len_i[w_win*PKT_LEN_W +: PKT_LEN_W];
  end

  assign grant_o                  = r_grant;
  assign tx_early_v_o             = r_early_v;
  assign tx_pkt_len_o             = r_pkt_len;
  assign tx_cancel_o              = r_cancel;
  assign req_ready_o              = (w_stream && tx_ready_i) ? r_grant : '0;
  assign tx_data_o                = req_data_i[r_gidx*DATA_W +: DATA_W];
  assign tx_len_o                 = req_len_i[r_gidx*LEN_W +: LEN_W];
  assign tx_last_o                = w_stream && req_last_i[r_gidx];
  assign tx_last_block_next_o     = w_stream && req_last_block_next_i[r_gidx];
  assign tx_last_block_next_len_o = req_last_block_next_len_i[r_gidx*LAST_LEN_W +: LAST_LEN_W];

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb at default parameters (REQ_N=2, DATA_W=16, IFG_CYC=3).
module tb_eth_tx_arb;

  logic        clk = 1'b0;
  logic        nreset;
  logic [1:0]  req_v_i;
  logic [31:0] req_pkt_len_i;
  logic [1:0]  req_cancel_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_len_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_last_block_next_i;
  logic [7:0]  req_last_block_next_len_i;
  logic [1:0]  grant_o;
  logic [1:0]  req_ready_o;
  logic        tx_early_v_o;
  logic [15:0] tx_pkt_len_o;
  logic        tx_cancel_o;
  logic [15:0] tx_data_o;
  logic [1:0]  tx_len_o;
  logic        tx_last_o;
  logic        tx_last_block_next_o;
  logic [3:0]  tx_last_block_next_len_o;
  logic        tx_ready_i;
  logic        tx_phy_idle_i;

  always #5 clk = ~clk;

  eth_tx_arb dut (
    .clk(clk), .nreset(nreset),
    .req_v_i(req_v_i), .req_pkt_len_i(req_pkt_len_i), .req_cancel_i(req_cancel_i),
    .req_data_i(req_data_i), .req_len_i(req_len_i), .req_last_i(req_last_i),
    .req_last_block_next_i(req_last_block_next_i),
    .req_last_block_next_len_i(req_last_block_next_len_i),
    .grant_o(grant_o), .req_ready_o(req_ready_o),
    .tx_early_v_o(tx_early_v_o), .tx_pkt_len_o(tx_pkt_len_o), .tx_cancel_o(tx_cancel_o),
    .tx_data_o(tx_data_o), .tx_len_o(tx_len_o), .tx_last_o(tx_last_o),
    .tx_last_block_next_o(tx_last_block_next_o),
    .tx_last_block_next_len_o(tx_last_block_next_len_o),
    .tx_ready_i(tx_ready_i), .tx_phy_idle_i(tx_phy_idle_i)
  );

  typedef struct {
    logic [15:0] d0, d1;
    logic [1:0]  l0, l1;
    logic [1:0]  last, lbn;
    logic [3:0]  n0, n1;
    logic        rdy;
    logic [15:0] e_data;
    logic [1:0]  e_len;
    logic        e_last, e_lbn;
    logic [3:0]  e_n;
    logic [1:0]  e_rr;
  } vec_t;

  vec_t vt[8];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(input string nm, output int cyc);
    cyc = 0;
    while (cyc < 60) begin
      step();
      cyc++;
      if (tx_early_v_o) break;
    end
    chk(nm, tx_early_v_o, 1'b1);
  endtask

  initial begin
    int cyc, zero, launches, dbl, ccnt;
    logic prev_early;
    logic [1:0] exp_g[3];

    vt[0] = '{16'hAAAA, 16'h1234, 2'd0, 2'd2, 2'b00, 2'b00, 4'hF, 4'h0, 1'b1,
              16'h1234, 2'd2, 1'b0, 1'b0, 4'h0, 2'b10};
    vt[1] = '{16'h5555, 16'hBEEF, 2'd1, 2'd2, 2'b01, 2'b10, 4'h3, 4'h7, 1'b0,
              16'hBEEF, 2'd2, 1'b0, 1'b1, 4'h7, 2'b00};
    vt[2] = '{16'hFFFF, 16'h0F0F, 2'd2, 2'd2, 2'b00, 2'b01, 4'h9, 4'h2, 1'b1,
              16'h0F0F, 2'd2, 1'b0, 1'b0, 4'h2, 2'b10};
    for (int i = 3; i < 7; i++)
      vt[i] = '{16'h0000, 16'h00C3, 2'd2, 2'd1, 2'b10, 2'b00, 4'h1, 4'h1, 1'b0,
                16'h00C3, 2'd1, 1'b1, 1'b0, 4'h1, 2'b00};
    vt[7] = '{16'h0000, 16'h00C3, 2'd2, 2'd1, 2'b10, 2'b00, 4'h1, 4'h1, 1'b1,
              16'h00C3, 2'd1, 1'b1, 1'b0, 4'h1, 2'b10};

    nreset = 1'b0; req_v_i = '0; req_pkt_len_i = {16'h0040, 16'h0123};
    req_cancel_i = '0; req_data_i = '0; req_len_i = '0; req_last_i = '0;
    req_last_block_next_i = '0; req_last_block_next_len_i = '0;
    tx_ready_i = 1'b1; tx_phy_idle_i = 1'b1;

    // reset state
    repeat (3) step();
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_early", tx_early_v_o, 1'b0);
    chk("rst_cancel", tx_cancel_o, 1'b0);
    chk("rst_ready", req_ready_o, 2'b00);
    nreset = 1'b1;

    // requester 1 alone: launch then table-driven stream
    req_v_i = 2'b10;
    step();
    chk("launch_early", tx_early_v_o, 1'b1);
    chk("launch_grant", grant_o, 2'b10);
    chk("launch_pkt_len", tx_pkt_len_o, 16'h0040);
    chk("launch_ready", req_ready_o, 2'b00);
    step();
    chk("stream_early", tx_early_v_o, 1'b0);
    tx_phy_idle_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_data_i = {vt[i].d1, vt[i].d0};
      req_len_i = {vt[i].l1, vt[i].l0};
      req_last_i = vt[i].last;
      req_last_block_next_i = vt[i].lbn;
      req_last_block_next_len_i = {vt[i].n1, vt[i].n0};
      tx_ready_i = vt[i].rdy;
      #1;
      chk($sformatf("v%0d_data", i), tx_data_o, vt[i].e_data);
      chk($sformatf("v%0d_len", i), tx_len_o, vt[i].e_len);
      chk($sformatf("v%0d_last", i), tx_last_o, vt[i].e_last);
      chk($sformatf("v%0d_lbn", i), tx_last_block_next_o, vt[i].e_lbn);
      chk($sformatf("v%0d_lbnlen", i), tx_last_block_next_len_o, vt[i].e_n);
      chk($sformatf("v%0d_req_ready", i), req_ready_o, vt[i].e_rr);
      step();
    end

    // drain waits for phy idle, grant held
    chk("drain_last", tx_last_o, 1'b0);
    chk("drain_grant", grant_o, 2'b10);
    chk("drain_ready", req_ready_o, 2'b00);
    step();
    chk("drain_hold_grant", grant_o, 2'b10);
    req_v_i = 2'b11; tx_phy_idle_i = 1'b1;
    zero = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (tx_early_v_o) break;
      if (grant_o == 2'b00) zero++;
    end
    chk("gap_launch_seen", tx_early_v_o, 1'b1);
    chk("gap_len_ok", zero >= 4, 1'b1);
    chk("rr_after_req1", grant_o, 2'b01);

    // both requesting: grants alternate, single early pulses, gap respected
    req_last_i = 2'b11; tx_ready_i = 1'b1;
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
    prev_early = 1'b1; zero = 0; launches = 0; dbl = 0;
    for (int c = 0; c < 80 && launches < 3; c++) begin
      step();
      if (tx_early_v_o) begin
        if (prev_early) dbl++;
        chk($sformatf("alt%0d_grant", launches), grant_o, exp_g[launches]);
        chk($sformatf("alt%0d_gap", launches), zero >= 4, 1'b1);
        launches++;
        zero = 0;
      end else if (grant_o == 2'b00) begin
        zero++;
      end
      prev_early = tx_early_v_o;
    end
    chk("alt_launches", launches, 3);
    chk("alt_early_double", dbl, 0);

    // cancel: non-granted ignored, granted aborts and advances pointer
    req_last_i = 2'b00;
    step();
    chk("cx_stream_grant", grant_o, 2'b10);
    chk("cx_stream_ready", req_ready_o, 2'b10);
    req_cancel_i = 2'b01;
    step();
    chk("cx_other_cancel", tx_cancel_o, 1'b0);
    chk("cx_other_grant", grant_o, 2'b10);
    req_cancel_i = 2'b10;
    step();
    chk("cx_cancel", tx_cancel_o, 1'b1);
    chk("cx_grant_clr", grant_o, 2'b00);
    chk("cx_ready_clr", req_ready_o, 2'b00);
    req_cancel_i = 2'b00;
    step();
    chk("cx_cancel_one", tx_cancel_o, 1'b0);
    wait_launch("cx_relaunch", cyc);
    chk("cx_rr_grant", grant_o, 2'b01);

    // reset mid-stream while requester 1 holds the grant
    req_last_i = 2'b11;
    wait_launch("rs_launch", cyc);
    chk("rs_pre_grant", grant_o, 2'b10);
    req_last_i = 2'b00;
    step();
    chk("rs_stream_ready", req_ready_o, 2'b10);
    nreset = 1'b0;
    step();
    chk("rs_grant", grant_o, 2'b00);
    chk("rs_early", tx_early_v_o, 1'b0);
    chk("rs_cancel", tx_cancel_o, 1'b0);
    chk("rs_ready", req_ready_o, 2'b00);
    nreset = 1'b1;
    wait_launch("rs_relaunch", cyc);
    chk("rs_relaunch_cyc", cyc, 1);
    chk("rs_rr_grant", grant_o, 2'b01);

    // stall with last pending: stays in stream, no spontaneous cancel
    tx_ready_i = 1'b0; req_last_i = 2'b11;
    ccnt = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (tx_cancel_o) ccnt++;
    end
`ifdef ETH_TX_ARB_WATCHDOG_EN
    chk("stall_cancel_seen", ccnt > 0, 1'b1);
`else
    chk("stall_no_cancel", ccnt, 0);
    chk("stall_last_held", tx_last_o, 1'b1);
    chk("stall_grant", grant_o, 2'b01);
    tx_ready_i = 1'b1;
    #1;
    chk("stall_ready", req_ready_o, 2'b01);
`endif

    // no grant while the phy is busy
    tx_ready_i = 1'b1; req_v_i = 2'b00;
    repeat (10) step();
    tx_phy_idle_i = 1'b0; req_v_i = 2'b01;
    ccnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (tx_early_v_o || grant_o != 2'b00) ccnt++;
    end
    chk("busy_phy_no_grant", ccnt, 0);
    tx_phy_idle_i = 1'b1;
    wait_launch("idle_phy_launch", cyc);
    chk("idle_phy_grant", grant_o, 2'b01);
    chk("idle_phy_pkt_len", tx_pkt_len_o, 16'h0123);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
